// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and frame constants shared by the UART receive and transmit datapaths.
//   rx_state_t : receiver FSM states
//   START_BIT  : line level of a start bit
//   STOP_BIT   : line level of a stop bit (also the idle level)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,   // line idle, waiting for a falling edge
    START,  // timing to the middle of the start bit
    DATA,   // sampling data bits, LSB first
    STOP,   // sampling the stop bit
    BREAK   // stop bit was low; wait for the line to return high
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchronizer for bringing an asynchronous level into the
// clk domain. Both flops reset to RESET_VAL so an idle-high line does not
// look like an edge when reset is released.
//   clk  : destination clock
//   rst  : asynchronous, active-high reset
//   d_i  : asynchronous input
//   q_o  : synchronized output (second flop)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit (0), n data bits LSB first, 1 stop bit (1).
// The serial input is synchronized, then each bit is sampled at its middle
// using a tick counter that runs over one bit period.
//
// Parameters
//   n            : data bits per frame (>= 2)
//   CLKS_PER_BIT : clk cycles per bit period (even, >= 4)
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high reset
//   Rx_in     : serial line, asynchronous to clk, idles high
//   D_out     : last correctly framed data word (holds until the next one)
//   valid     : one-cycle pulse, D_out was updated this cycle
//   frame_err : one-cycle pulse, stop bit sampled low (D_out unchanged)
//   busy      : high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Rx_in,
  output logic [n-1:0] D_out,
  output logic         valid,
  output logic         frame_err,
  output logic         busy
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(n + 1);

  // START waits half a bit so that all later samples land mid-bit.
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(n - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic rx_s;

  sync_2ff #(
    .RESET_VAL (STOP_BIT)
  ) u_sync (
    .clk (clk),
    .rst (reset),
    .d_i (Rx_in),
    .q_o (rx_s)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rx_state_t         state_q,     state_d;
  logic [TICK_W-1:0] tick_q,      tick_d;
  logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [n-1:0]      shreg_q,     shreg_d;
  logic [n-1:0]      d_out_q,     d_out_d;
  logic              valid_q,     valid_d;
  logic              frame_err_q, frame_err_d;

  // NOTE: the shift register is a plain datapath register, but it is small
  // and reset anyway so the whole receiver starts from a known state; only
  // D_out is architecturally visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      d_out_q     <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      d_out_q     <= d_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case statement, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    d_out_d     = d_out_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_d    = '0;
        bit_cnt_d = '0;
        if (rx_s == START_BIT) begin
          state_d = START;
        end
      end

      START: begin
        if (tick_q == TICK_HALF) begin
          tick_d    = '0;
          bit_cnt_d = '0;
          // A line that is already high again at mid-start was a glitch.
          state_d   = (rx_s == START_BIT) ? DATA : IDLE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          // LSB arrives first: shift right so it ends up in bit 0.
          shreg_d   = {rx_s, shreg_q[n-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rx_s == STOP_BIT) begin
            d_out_d = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      BREAK: begin
        // A held-low line must not be mistaken for a new start bit.
        tick_d = '0;
        if (rx_s == STOP_BIT) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign D_out     = d_out_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed frames for uart_rx (n=8, CLKS_PER_BIT=16). Each frame pushes its
// expected pulse (kind, D_out value, cycle) into a queue; a monitor on the
// falling clock edge pops and compares whenever valid or frame_err is high.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int N   = 8;
  localparam int CPB = 16;
  // Rx_in goes low at a falling edge; E0 is the next rising edge (+1) and the
  // pulse is high after edge E0+154, so it is seen at cyc = start + 155.
  localparam int PULSE_LAT = 155;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       Rx_in;
  logic [7:0] D_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int         checks    = 0;
  int         failures  = 0;
  int         cyc       = 0;
  logic [7:0] last_good = 8'h00;
  exp_t       sb[$];

  uart_rx #(
    .n            (N),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Rx_in     (Rx_in),
    .D_out     (D_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; returns at the falling edge that ends the stop bit.
  task automatic send_frame(input logic [7:0] data, input logic stop);
    exp_t       e;
    logic [9:0] bits;
    bits     = {stop, data, 1'b0};
    e.is_err = !stop;
    e.data   = stop ? data : last_good;
    e.cyc    = cyc + PULSE_LAT;
    sb.push_back(e);
    if (stop) last_good = data;
    for (int i = 0; i < 10; i++) begin
      Rx_in = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (valid === 1'b1 && frame_err === 1'b1)
      check("valid_and_frame_err", 32'(valid & frame_err), 32'd0);
    if (valid === 1'b1 || frame_err === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b D_out=0x%0h at cycle %0d",
                 valid, frame_err, D_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind_frame_err", 32'(frame_err), 32'(e.is_err));
        check("pulse_d_out", 32'(D_out), 32'(e.data));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] partial;

    // Reset: outputs must clear before any clock edge.
    reset = 1'b0;
    Rx_in = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("reset_d_out", 32'(D_out), 32'h00);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    idle(3);
    reset = 1'b0;
    idle(5);
    check("idle_busy", 32'(busy), 32'd0);

    // Single good frame.
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("a5_busy_after", 32'(busy), 32'd0);
    check("a5_d_out_hold", 32'(D_out), 32'hA5);

    // Start glitch: four low cycles only.
    Rx_in = 1'b0;
    idle(4);
    Rx_in = 1'b1;
    idle(1);
    check("glitch_busy_high", 32'(busy), 32'd1);
    idle(10);
    check("glitch_busy_low", 32'(busy), 32'd0);
    idle(5);
    send_frame(8'h3C, 1'b1);
    idle(20);

    // Framing error followed by a held-low line.
    send_frame(8'h3C, 1'b0);
    idle(40);
    check("break_busy_high", 32'(busy), 32'd1);
    check("break_d_out_hold", 32'(D_out), 32'h3C);
    Rx_in = 1'b1;
    idle(5);
    check("break_busy_low", 32'(busy), 32'd0);
    idle(15);
    send_frame(8'h0F, 1'b1);
    idle(20);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("b2b_d_out", 32'(D_out), 32'hFF);

    // Reset after data bit 3 has been sampled.
    partial = 8'hC3;
    Rx_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      Rx_in = partial[i];
      idle(CPB);
    end
    reset = 1'b1;
    Rx_in = 1'b1;
    #1;
    check("midreset_d_out", 32'(D_out), 32'h00);
    check("midreset_valid", 32'(valid), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    last_good = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(20);
    check("midreset_d_out_after", 32'(D_out), 32'h00);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check("final_d_out", 32'(D_out), 32'h5A);

    check("pending_expectations", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx
